// File: rtl/nway_cache_control_if.sv
// Signal bundle between the CPU/datapath side and the N-way cache controller.
// The master drives requests, array status and pmem_resp; the controller (slave) answers.
interface nway_cache_control_if #(
    parameter int WAYS  = 4,
    parameter int SET_W = 3,
    parameter int CNT_W = 16
);
    logic             mem_read;
    logic             mem_write;
    logic [SET_W-1:0] set_idx;
    logic [WAYS-1:0]  hit_way;
    logic [WAYS-1:0]  valid_way;
    logic [WAYS-1:0]  dirty_way;
    logic             pmem_resp;
    logic             mem_resp;
    logic             pmem_read;
    logic             pmem_write;
    logic             addr_out_sel;
    logic             data_in_sel;
    logic [WAYS-1:0]  way_sel;
    logic             data_load;
    logic             tag_load;
    logic             valid_load;
    logic             dirty_load;
    logic             dirty_in;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    modport master (
        output mem_read, mem_write, set_idx, hit_way, valid_way, dirty_way, pmem_resp,
        input  mem_resp, pmem_read, pmem_write, addr_out_sel, data_in_sel, way_sel,
               data_load, tag_load, valid_load, dirty_load, dirty_in, hit_cnt, miss_cnt
    );

    modport slave (
        input  mem_read, mem_write, set_idx, hit_way, valid_way, dirty_way, pmem_resp,
        output mem_resp, pmem_read, pmem_write, addr_out_sel, data_in_sel, way_sel,
               data_load, tag_load, valid_load, dirty_load, dirty_in, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/nway_cache_control.sv
// Control FSM for an N-way set-associative write-back/write-allocate cache with
// per-set tree pseudo-LRU replacement and saturating hit/miss statistics.
module nway_cache_control #(
    parameter int WAYS  = 4,
    parameter int SET_W = 3,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    nway_cache_control_if.slave bus
);
    localparam int IDX_W = $clog2(WAYS);
    localparam int SETS  = 2 ** SET_W;
    localparam int NODES = WAYS - 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [NODES-1:0] r_plru [SETS];
    logic [IDX_W-1:0] r_victim;
    logic [CNT_W-1:0] r_hitCnt;
    logic [CNT_W-1:0] r_missCnt;

    logic             w_req;
    logic [IDX_W-1:0] w_hitIdx;
    logic [IDX_W-1:0] w_missVictim;
    logic             w_touch;
    logic [IDX_W-1:0] w_touchWay;
    logic             w_hitEvent;
    logic             w_missEvent;
    logic             w_latchVictim;

    function automatic logic [IDX_W-1:0] lowestSet(input logic [WAYS-1:0] vec);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Heap-ordered tree: node n (1-based) lives in bit n-1, children are 2n and 2n+1.
    function automatic logic [IDX_W-1:0] plruVictim(input logic [NODES-1:0] tree);
        logic [IDX_W-1:0] way;
        int               node;
        way  = '0;
        node = 1;
        for (int lvl = 0; lvl < IDX_W; lvl++) begin
            way[IDX_W-1-lvl] = tree[node-1];
            node = 2 * node + (tree[node-1] ? 1 : 0);
        end
        return way;
    endfunction

    function automatic logic [NODES-1:0] plruTouch(input logic [NODES-1:0] tree,
                                                   input logic [IDX_W-1:0] way);
        logic [NODES-1:0] t;
        int               node;
        t    = tree;
        node = 1;
        for (int lvl = 0; lvl < IDX_W; lvl++) begin
            t[node-1] = ~way[IDX_W-1-lvl];
            node = 2 * node + (way[IDX_W-1-lvl] ? 1 : 0);
        end
        return t;
    endfunction

    assign w_req        = bus.mem_read | bus.mem_write;
    assign w_hitIdx     = lowestSet(bus.hit_way);
    assign w_missVictim = (&bus.valid_way) ? plruVictim(r_plru[bus.set_idx])
                                           : lowestSet(~bus.valid_way);
    assign bus.hit_cnt  = r_hitCnt;
    assign bus.miss_cnt = r_missCnt;

    // Next state and all datapath strobes; everything is forced low while reset is held.
    always_comb begin
        w_nextState      = r_state;
        w_touch          = 1'b0;
        w_touchWay       = '0;
        w_hitEvent       = 1'b0;
        w_missEvent      = 1'b0;
        w_latchVictim    = 1'b0;
        bus.mem_resp     = 1'b0;
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.addr_out_sel = 1'b0;
        bus.data_in_sel  = 1'b0;
        bus.way_sel      = '0;
        bus.data_load    = 1'b0;
        bus.tag_load     = 1'b0;
        bus.valid_load   = 1'b0;
        bus.dirty_load   = 1'b0;
        bus.dirty_in     = 1'b0;
        if (rst_n) begin
            case (r_state)
                IDLE: begin
                    if (w_req && (|bus.hit_way)) begin
                        bus.mem_resp = 1'b1;
                        bus.way_sel  = WAYS'(1) << w_hitIdx;
                        if (bus.mem_write) begin
                            bus.data_load  = 1'b1;
                            bus.dirty_load = 1'b1;
                            bus.dirty_in   = 1'b1;
                        end
                        w_touch    = 1'b1;
                        w_touchWay = w_hitIdx;
                        w_hitEvent = 1'b1;
                    end else if (w_req) begin
                        w_missEvent   = 1'b1;
                        w_latchVictim = 1'b1;
                        w_nextState   = (bus.valid_way[w_missVictim] && bus.dirty_way[w_missVictim])
                                        ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    bus.pmem_write   = 1'b1;
                    bus.addr_out_sel = 1'b1;
                    bus.way_sel      = WAYS'(1) << r_victim;
                    if (bus.pmem_resp) w_nextState = FILL;
                end
                FILL: begin
                    bus.pmem_read   = 1'b1;
                    bus.data_in_sel = 1'b1;
                    bus.way_sel     = WAYS'(1) << r_victim;
                    if (bus.pmem_resp) begin
                        bus.data_load  = 1'b1;
                        bus.tag_load   = 1'b1;
                        bus.valid_load = 1'b1;
                        bus.dirty_load = 1'b1;
                        w_touch        = 1'b1;
                        w_touchWay     = r_victim;
                        w_nextState    = IDLE;
                    end
                end
                default: w_nextState = IDLE;
            endcase
        end
    end

    // State, victim latch, replacement trees and saturating statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_victim  <= '0;
            r_hitCnt  <= '0;
            r_missCnt <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_plru[s] <= '0;
            end
        end else begin
            r_state <= w_nextState;
            if (w_latchVictim) r_victim <= w_missVictim;
            if (w_touch) r_plru[bus.set_idx] <= plruTouch(r_plru[bus.set_idx], w_touchWay);
            if (w_hitEvent && (r_hitCnt != CNT_MAX)) r_hitCnt <= r_hitCnt + 1'b1;
            if (w_missEvent && (r_missCnt != CNT_MAX)) r_missCnt <= r_missCnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_nway_cache_control.sv
// Directed bench for nway_cache_control: a per-cycle reference model of the cache
// protocol plus hand-computed literal expectations for each scenario.
module tb_nway_cache_control;
    localparam int WAYS    = 4;
    localparam int SET_W   = 3;
    localparam int CNT_W   = 2;
    localparam int SETS    = 2 ** SET_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   nChecks = 0;
    int   nFails  = 0;

    nway_cache_control_if #(.WAYS(WAYS), .SET_W(SET_W), .CNT_W(CNT_W)) bus ();

    nway_cache_control #(.WAYS(WAYS), .SET_W(SET_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model state: phase 0=idle, 1=write-back, 2=fill; tree node n of a set in mTree[set][n].
    int mPhase, mVictim, mHits, mMisses;
    int mTree [SETS][WAYS];
    int nPhase, nVictim, nHits, nMisses, nTouchWay, nSet;

    task automatic checkOutput(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFails++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int firstOne(input logic [WAYS-1:0] vec);
        for (int i = 0; i < WAYS; i++) if (vec[i]) return i;
        return -1;
    endfunction

    function automatic int treeVictim(input int s);
        int lo = 0, size = WAYS, node = 1, half;
        while (size > 1) begin
            half = size / 2;
            if (mTree[s][node] == 0) node = 2 * node;
            else begin
                lo   = lo + half;
                node = 2 * node + 1;
            end
            size = half;
        end
        return lo;
    endfunction

    function automatic void treeTouch(input int s, input int w);
        int lo = 0, size = WAYS, node = 1, half;
        while (size > 1) begin
            half = size / 2;
            if (w < lo + half) begin
                mTree[s][node] = 1;
                node = 2 * node;
            end else begin
                mTree[s][node] = 0;
                lo   = lo + half;
                node = 2 * node + 1;
            end
            size = half;
        end
    endfunction

    task automatic evalModel();
        int eResp = 0, ePR = 0, ePW = 0, eAddr = 0, eDin = 0, eWay = 0;
        int eData = 0, eTag = 0, eValid = 0, eDirtyL = 0, eDirtyIn = 0;
        int w, v;
        if (!rst_n) begin
            mPhase = 0; mVictim = 0; mHits = 0; mMisses = 0;
            for (int s = 0; s < SETS; s++) for (int n = 0; n < WAYS; n++) mTree[s][n] = 0;
        end
        nPhase = mPhase; nVictim = mVictim; nHits = mHits; nMisses = mMisses;
        nTouchWay = -1; nSet = int'(bus.set_idx);
        if (rst_n) begin
            case (mPhase)
                0: if (bus.mem_read || bus.mem_write) begin
                    if (bus.hit_way != '0) begin
                        w = firstOne(bus.hit_way);
                        eResp = 1;
                        eWay  = 1 << w;
                        if (bus.mem_write) begin
                            eData = 1; eDirtyL = 1; eDirtyIn = 1;
                        end
                        nTouchWay = w;
                        nHits = (mHits < CNT_MAX) ? mHits + 1 : CNT_MAX;
                    end else begin
                        v = (bus.valid_way == '1) ? treeVictim(nSet) : firstOne(~bus.valid_way);
                        nVictim = v;
                        nMisses = (mMisses < CNT_MAX) ? mMisses + 1 : CNT_MAX;
                        nPhase  = (bus.valid_way[v] && bus.dirty_way[v]) ? 1 : 2;
                    end
                end
                1: begin
                    ePW = 1; eAddr = 1; eWay = 1 << mVictim;
                    if (bus.pmem_resp) nPhase = 2;
                end
                default: begin
                    ePR = 1; eDin = 1; eWay = 1 << mVictim;
                    if (bus.pmem_resp) begin
                        eData = 1; eTag = 1; eValid = 1; eDirtyL = 1;
                        nTouchWay = mVictim;
                        nPhase = 0;
                    end
                end
            endcase
        end
        checkOutput("model mem_resp", int'(bus.mem_resp), eResp);
        checkOutput("model pmem_read", int'(bus.pmem_read), ePR);
        checkOutput("model pmem_write", int'(bus.pmem_write), ePW);
        checkOutput("model addr_out_sel", int'(bus.addr_out_sel), eAddr);
        checkOutput("model data_in_sel", int'(bus.data_in_sel), eDin);
        checkOutput("model way_sel", int'(bus.way_sel), eWay);
        checkOutput("model data_load", int'(bus.data_load), eData);
        checkOutput("model tag_load", int'(bus.tag_load), eTag);
        checkOutput("model valid_load", int'(bus.valid_load), eValid);
        checkOutput("model dirty_load", int'(bus.dirty_load), eDirtyL);
        checkOutput("model dirty_in", int'(bus.dirty_in), eDirtyIn);
        checkOutput("model hit_cnt", int'(bus.hit_cnt), mHits);
        checkOutput("model miss_cnt", int'(bus.miss_cnt), mMisses);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            evalModel();
            @(posedge clk);
            if (rst_n) begin
                mPhase = nPhase; mVictim = nVictim; mHits = nHits; mMisses = nMisses;
                if (nTouchWay >= 0) treeTouch(nSet, nTouchWay);
            end
        end
    end

    task automatic applyStimulus(input logic rd, input logic wr, input int set,
                                 input logic [WAYS-1:0] hit, input logic [WAYS-1:0] valid,
                                 input logic [WAYS-1:0] dirty, input logic presp);
        bus.mem_read  = rd;
        bus.mem_write = wr;
        bus.set_idx   = SET_W'(set);
        bus.hit_way   = hit;
        bus.valid_way = valid;
        bus.dirty_way = dirty;
        bus.pmem_resp = presp;
        @(negedge clk);
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.set_idx = '0;
        bus.hit_way = '0; bus.valid_way = '0; bus.dirty_way = '0; bus.pmem_resp = 1'b0;

        // Reset holds every output low even with a hitting request present.
        applyStimulus(1, 0, 0, 4'b0001, 4'b0001, 4'b0000, 1);
        checkOutput("reset mem_resp", int'(bus.mem_resp), 0);
        checkOutput("reset way_sel", int'(bus.way_sel), 0);
        checkOutput("reset hit_cnt", int'(bus.hit_cnt), 0);
        advance();
        rst_n = 1'b1;

        // Cold read of set 0: victim way 0, clean, straight to FILL.
        applyStimulus(1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        checkOutput("cold miss mem_resp", int'(bus.mem_resp), 0);
        checkOutput("cold miss pmem_write", int'(bus.pmem_write), 0);
        advance();
        applyStimulus(1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0);
        checkOutput("cold fill way_sel", int'(bus.way_sel), 4'b0001);
        checkOutput("cold fill pmem_read", int'(bus.pmem_read), 1);
        checkOutput("cold fill early data_load", int'(bus.data_load), 0);
        advance();
        applyStimulus(1, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1);
        checkOutput("cold fill valid_load", int'(bus.valid_load), 1);
        checkOutput("cold fill tag_load", int'(bus.tag_load), 1);
        checkOutput("cold fill data_load", int'(bus.data_load), 1);
        advance();
        applyStimulus(1, 0, 0, 4'b0001, 4'b0001, 4'b0000, 0);
        checkOutput("cold relookup mem_resp", int'(bus.mem_resp), 1);
        checkOutput("cold miss_cnt", int'(bus.miss_cnt), 1);
        advance();

        // Set 2, all valid and clean: hit way 0, then the miss evicts way 2.
        applyStimulus(1, 0, 2, 4'b0001, 4'b1111, 4'b0000, 0);
        checkOutput("plru hit way_sel", int'(bus.way_sel), 4'b0001);
        checkOutput("plru hit_cnt before", int'(bus.hit_cnt), 1);
        advance();
        applyStimulus(1, 0, 2, 4'b0000, 4'b1111, 4'b0000, 0);
        checkOutput("plru miss mem_resp", int'(bus.mem_resp), 0);
        advance();
        applyStimulus(1, 0, 2, 4'b0000, 4'b1111, 4'b0000, 1);
        checkOutput("plru victim way_sel", int'(bus.way_sel), 4'b0100);
        checkOutput("plru victim no writeback", int'(bus.pmem_write), 0);
        advance();
        applyStimulus(1, 0, 2, 4'b0100, 4'b1111, 4'b0000, 0);
        checkOutput("plru relookup mem_resp", int'(bus.mem_resp), 1);
        advance();

        // Next victim in set 2 is way 1, now dirty: WRITEBACK then FILL.
        applyStimulus(1, 0, 2, 4'b0000, 4'b1111, 4'b0010, 0);
        checkOutput("dirty miss_cnt before", int'(bus.miss_cnt), 2);
        advance();
        applyStimulus(1, 0, 2, 4'b0000, 4'b1111, 4'b0010, 0);
        checkOutput("wb pmem_write", int'(bus.pmem_write), 1);
        checkOutput("wb addr_out_sel", int'(bus.addr_out_sel), 1);
        checkOutput("wb way_sel", int'(bus.way_sel), 4'b0010);
        checkOutput("wb pmem_read", int'(bus.pmem_read), 0);
        advance();
        applyStimulus(1, 0, 2, 4'b0000, 4'b1111, 4'b0010, 1);
        checkOutput("wb resp pmem_write", int'(bus.pmem_write), 1);
        advance();
        applyStimulus(1, 0, 2, 4'b0000, 4'b1111, 4'b0010, 0);
        checkOutput("wb->fill pmem_read", int'(bus.pmem_read), 1);
        checkOutput("wb->fill pmem_write", int'(bus.pmem_write), 0);
        checkOutput("wb->fill data_in_sel", int'(bus.data_in_sel), 1);
        advance();
        applyStimulus(1, 0, 2, 4'b0000, 4'b1111, 4'b0010, 1);
        checkOutput("wb fill dirty_load", int'(bus.dirty_load), 1);
        checkOutput("wb fill dirty_in", int'(bus.dirty_in), 0);
        advance();
        applyStimulus(1, 0, 2, 4'b0010, 4'b1111, 4'b0000, 0);
        checkOutput("wb relookup mem_resp", int'(bus.mem_resp), 1);
        advance();

        // Abort a fill with reset; trees clear so the retry victim is way 0.
        applyStimulus(1, 0, 2, 4'b0000, 4'b1111, 4'b0000, 0);
        checkOutput("sat hit_cnt", int'(bus.hit_cnt), 3);
        checkOutput("sat miss_cnt", int'(bus.miss_cnt), 3);
        advance();
        applyStimulus(1, 0, 2, 4'b0000, 4'b1111, 4'b0000, 0);
        checkOutput("abort fill way_sel", int'(bus.way_sel), 4'b1000);
        advance();
        rst_n = 1'b0;
        applyStimulus(1, 0, 2, 4'b0000, 4'b1111, 4'b0000, 1);
        checkOutput("abort data_load", int'(bus.data_load), 0);
        checkOutput("abort valid_load", int'(bus.valid_load), 0);
        checkOutput("abort pmem_read", int'(bus.pmem_read), 0);
        checkOutput("abort miss_cnt", int'(bus.miss_cnt), 0);
        advance();
        rst_n = 1'b1;
        applyStimulus(1, 0, 2, 4'b0000, 4'b1111, 4'b0000, 0);
        checkOutput("retry miss mem_resp", int'(bus.mem_resp), 0);
        advance();
        applyStimulus(1, 0, 2, 4'b0000, 4'b1111, 4'b0000, 1);
        checkOutput("retry victim way_sel", int'(bus.way_sel), 4'b0001);
        advance();
        applyStimulus(1, 0, 2, 4'b0001, 4'b1111, 4'b0000, 0);
        checkOutput("retry relookup mem_resp", int'(bus.mem_resp), 1);
        advance();

        // Write hit way 3, multi-hot hit, read+write treated as write.
        applyStimulus(0, 1, 5, 4'b1000, 4'b1111, 4'b0000, 0);
        checkOutput("write hit mem_resp", int'(bus.mem_resp), 1);
        checkOutput("write hit data_load", int'(bus.data_load), 1);
        checkOutput("write hit dirty_in", int'(bus.dirty_in), 1);
        checkOutput("write hit way_sel", int'(bus.way_sel), 4'b1000);
        checkOutput("write hit hit_cnt before", int'(bus.hit_cnt), 1);
        advance();
        applyStimulus(1, 0, 5, 4'b0110, 4'b1111, 4'b0000, 0);
        checkOutput("multihot way_sel", int'(bus.way_sel), 4'b0010);
        checkOutput("multihot data_load", int'(bus.data_load), 0);
        checkOutput("write hit hit_cnt after", int'(bus.hit_cnt), 2);
        advance();
        applyStimulus(1, 1, 5, 4'b0001, 4'b1111, 4'b0000, 0);
        checkOutput("rdwr dirty_in", int'(bus.dirty_in), 1);
        checkOutput("rdwr data_load", int'(bus.data_load), 1);
        advance();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 0, 5, 4'b0100, 4'b1111, 4'b0000, 0);
            advance();
        end

        // One more miss on an empty set; hit counter stays saturated.
        applyStimulus(1, 0, 7, 4'b0000, 4'b0000, 4'b0000, 0);
        checkOutput("hit_cnt saturated", int'(bus.hit_cnt), 3);
        advance();
        applyStimulus(1, 0, 7, 4'b0000, 4'b0000, 4'b0000, 1);
        advance();
        applyStimulus(0, 0, 7, 4'b0000, 4'b0000, 4'b0000, 0);
        checkOutput("final miss_cnt", int'(bus.miss_cnt), 2);
        checkOutput("idle mem_resp", int'(bus.mem_resp), 0);
        advance();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
